// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single memory port, one outstanding transaction.
// Define MEM_ARB_LSU_PRIO_EN for fixed LSU priority; default build is round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t              state_r;
  owner_t              owner_r;
  owner_t              last_grant_r;
  logic                req_valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [MASK_W-1:0]   wmask_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                ifu_resp_valid_r;
  logic                lsu_resp_valid_r;
  logic                ifu_grant_s;
  logic                lsu_grant_s;

  // Grant selection; only in IDLE and never while reset is asserted
  always_comb begin
    ifu_grant_s = 1'b0;
    lsu_grant_s = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
`ifdef MEM_ARB_LSU_PRIO_EN
      if (lsu_req_valid) begin
        lsu_grant_s = 1'b1;
      end else if (ifu_req_valid) begin
        ifu_grant_s = 1'b1;
      end else begin
        lsu_grant_s = 1'b0;
      end
`else
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_grant_r == OWN_LSU) begin
          ifu_grant_s = 1'b1;
        end else begin
          lsu_grant_s = 1'b1;
        end
      end else if (ifu_req_valid) begin
        ifu_grant_s = 1'b1;
      end else if (lsu_req_valid) begin
        lsu_grant_s = 1'b1;
      end else begin
        ifu_grant_s = 1'b0;
      end
`endif
    end else begin
      ifu_grant_s = 1'b0;
      lsu_grant_s = 1'b0;
    end
  end

  // Transaction FSM with latched request fields and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      owner_r          <= OWN_IFU;
      last_grant_r     <= OWN_LSU;
      req_valid_r      <= 1'b0;
      addr_r           <= '0;
      wen_r            <= 1'b0;
      wdata_r          <= '0;
      wmask_r          <= '0;
      resp_data_r      <= '0;
      ifu_resp_valid_r <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
    end else begin
      ifu_resp_valid_r <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ifu_grant_s) begin
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_IFU;
            addr_r       <= ifu_req_addr;
            wen_r        <= 1'b0;
            wdata_r      <= '0;
            wmask_r      <= '0;
            req_valid_r  <= 1'b1;
            state_r      <= ST_REQ;
          end else if (lsu_grant_s) begin
            owner_r      <= OWN_LSU;
            last_grant_r <= OWN_LSU;
            addr_r       <= lsu_req_addr;
            wen_r        <= lsu_req_wen;
            wdata_r      <= lsu_req_wdata;
            wmask_r      <= lsu_req_wmask;
            req_valid_r  <= 1'b1;
            state_r      <= ST_REQ;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            state_r     <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            resp_data_r <= mem_resp_data;
            state_r     <= ST_IDLE;
            if (owner_r == OWN_IFU) begin
              ifu_resp_valid_r <= 1'b1;
            end else begin
              lsu_resp_valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          req_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ifu_req_ready  = ifu_grant_s;
  assign lsu_req_ready  = lsu_grant_s;
  assign ifu_resp_valid = ifu_resp_valid_r;
  assign lsu_resp_valid = lsu_resp_valid_r;
  assign ifu_resp_data  = resp_data_r;
  assign lsu_resp_data  = resp_data_r;
  assign mem_req_valid  = req_valid_r;
  assign mem_req_addr   = addr_r;
  assign mem_req_wen    = wen_r;
  assign mem_req_wdata  = wdata_r;
  assign mem_req_wmask  = wmask_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled just after negedge.
module tb_mem_arbiter;

`ifdef MEM_ARB_LSU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic apply_reset();
    reset = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = 64'h0;
    lsu_req_valid = 1'b0; lsu_req_addr = 64'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h00;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    reset = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    total++; if (ifu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ifu_ready got=%0h exp=0", ifu_req_ready); end
    total++; if (lsu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_lsu_ready got=%0h exp=0", lsu_req_ready); end
    @(negedge clock); #1;
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0h exp=0", mem_req_valid); end
    total++; if (mem_req_addr !== 64'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_req_addr); end
    total++; if (mem_req_wdata !== 64'h0 || mem_req_wmask !== 8'h00 || mem_req_wen !== 1'b0) begin
      bad++; $display("FAIL rst_mem_fields got=%0h/%0h/%0h exp=0/0/0", mem_req_wdata, mem_req_wmask, mem_req_wen); end
    total++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp_valid got=%0h/%0h exp=0/0", ifu_resp_valid, lsu_resp_valid); end
    total++; if (ifu_resp_data !== 64'h0) begin bad++; $display("FAIL rst_resp_data got=%0h exp=0", ifu_resp_data); end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_ifu_read();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000; mem_req_ready = 1'b1;
    #1;
    total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL ifu_rd_ready got=%0h exp=1", ifu_req_ready); end
    total++; if (lsu_req_ready !== 1'b0) begin bad++; $display("FAIL ifu_rd_lsu_ready got=%0h exp=0", lsu_req_ready); end
    @(negedge clock);
    ifu_req_valid = 1'b0; ifu_req_addr = 64'h0;
    #1;
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL ifu_rd_mem_valid got=%0h exp=1", mem_req_valid); end
    total++; if (mem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL ifu_rd_addr got=%0h exp=80000000", mem_req_addr); end
    total++; if (mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) begin
      bad++; $display("FAIL ifu_rd_wen_mask got=%0h/%0h exp=0/0", mem_req_wen, mem_req_wmask); end
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h00000013_00100093;
    #1;
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL ifu_rd_wait_valid got=%0h exp=0", mem_req_valid); end
    @(negedge clock);
    mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
    #1;
    total++; if (ifu_resp_valid !== 1'b1) begin bad++; $display("FAIL ifu_rd_resp got=%0h exp=1", ifu_resp_valid); end
    total++; if (ifu_resp_data !== 64'h00000013_00100093) begin bad++; $display("FAIL ifu_rd_data got=%0h exp=0000001300100093", ifu_resp_data); end
    total++; if (lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL ifu_rd_lsu_resp got=%0h exp=0", lsu_resp_valid); end
    @(negedge clock); #1;
    total++; if (ifu_resp_valid !== 1'b0) begin bad++; $display("FAIL ifu_rd_pulse_end got=%0h exp=0", ifu_resp_valid); end
    total++; if (ifu_resp_data !== 64'h00000013_00100093) begin bad++; $display("FAIL ifu_rd_data_hold got=%0h exp=0000001300100093", ifu_resp_data); end
  endtask

  task automatic test_lsu_write();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'hDEADBEEF_CAFEF00D; lsu_req_wmask = 8'h0F; mem_req_ready = 1'b1;
    #1;
    total++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
      bad++; $display("FAIL lsu_wr_ready got=%0h/%0h exp=1/0", lsu_req_ready, ifu_req_ready); end
    @(negedge clock);
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h00;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000) begin
      bad++; $display("FAIL lsu_wr_addr got=%0h/%0h exp=1/80001000", mem_req_valid, mem_req_addr); end
    total++; if (mem_req_wen !== 1'b1) begin bad++; $display("FAIL lsu_wr_wen got=%0h exp=1", mem_req_wen); end
    total++; if (mem_req_wdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL lsu_wr_wdata got=%0h exp=deadbeefcafef00d", mem_req_wdata); end
    total++; if (mem_req_wmask !== 8'h0F) begin bad++; $display("FAIL lsu_wr_wmask got=%0h exp=0f", mem_req_wmask); end
    @(negedge clock);
    mem_resp_valid = 1'b1;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL lsu_wr_resp got=%0h/%0h exp=1/0", lsu_resp_valid, ifu_resp_valid); end
    @(negedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL lsu_wr_pulse_end got=%0h exp=0", lsu_resp_valid); end
  endtask

  task automatic test_conflict();
    logic [63:0] a_i, a_l, win_addr, lose_addr;
    a_i = 64'h1000_0000; a_l = 64'h2000_0008;
    win_addr  = PRIO ? a_l : a_i;
    lose_addr = PRIO ? a_i : a_l;
    apply_reset();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_req_addr = a_i;
    lsu_req_valid = 1'b1; lsu_req_addr = a_l; lsu_req_wen = 1'b0; lsu_req_wmask = 8'hFF;
    mem_req_ready = 1'b1;
    #1;
    total++; if (ifu_req_ready !== !PRIO || lsu_req_ready !== PRIO) begin
      bad++; $display("FAIL conf_first got=%0h/%0h exp=%0h/%0h", ifu_req_ready, lsu_req_ready, !PRIO, PRIO); end
    @(negedge clock);
    if (PRIO) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    #1;
    total++; if (mem_req_addr !== win_addr) begin bad++; $display("FAIL conf_first_addr got=%0h exp=%0h", mem_req_addr, win_addr); end
    total++; if (mem_req_wmask !== (PRIO ? 8'hFF : 8'h00)) begin
      bad++; $display("FAIL conf_first_mask got=%0h exp=%0h", mem_req_wmask, (PRIO ? 8'hFF : 8'h00)); end
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h1111;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (ifu_req_ready !== PRIO || lsu_req_ready !== !PRIO) begin
      bad++; $display("FAIL conf_second got=%0h/%0h exp=%0h/%0h", ifu_req_ready, lsu_req_ready, PRIO, !PRIO); end
    @(negedge clock);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    total++; if (mem_req_addr !== lose_addr) begin bad++; $display("FAIL conf_second_addr got=%0h exp=%0h", mem_req_addr, lose_addr); end
    total++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
      bad++; $display("FAIL conf_req_ready got=%0h/%0h exp=0/0", ifu_req_ready, lsu_req_ready); end
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h2222;
    #1;
    total++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
      bad++; $display("FAIL conf_wait_ready got=%0h/%0h exp=0/0", ifu_req_ready, lsu_req_ready); end
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (ifu_req_ready !== !PRIO || lsu_req_ready !== PRIO) begin
      bad++; $display("FAIL conf_third got=%0h/%0h exp=%0h/%0h", ifu_req_ready, lsu_req_ready, !PRIO, PRIO); end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h0000_0001_2345_6787; lsu_req_wen = 1'b1;
    lsu_req_wdata = 64'h0123_4567_89AB_CDEF; lsu_req_wmask = 8'hA5; mem_req_ready = 1'b0;
    #1;
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%0h exp=1", lsu_req_ready); end
    @(negedge clock);
    lsu_req_valid = 1'b0; lsu_req_addr = 64'h0; lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h00;
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h9000;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = (i == 2);
      #1;
      total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h0000_0001_2345_6787) begin
        bad++; $display("FAIL bp_hold_addr cyc=%0d got=%0h/%0h exp=1/123456787", i, mem_req_valid, mem_req_addr); end
      total++; if (mem_req_wdata !== 64'h0123_4567_89AB_CDEF || mem_req_wmask !== 8'hA5 || mem_req_wen !== 1'b1) begin
        bad++; $display("FAIL bp_hold_fields cyc=%0d got=%0h/%0h/%0h exp=123456789abcdef/a5/1", i, mem_req_wdata, mem_req_wmask, mem_req_wen); end
      total++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready cyc=%0d got=%0h/%0h exp=0/0", i, ifu_req_ready, lsu_req_ready); end
      @(negedge clock);
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1; ifu_req_valid = 1'b0;
    #1;
    total++; if (lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL bp_spurious got=%0h/%0h exp=0/1", lsu_resp_valid, mem_req_valid); end
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 64'h5A5A_0F0F_3C3C_9696;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'h5A5A_0F0F_3C3C_9696) begin
      bad++; $display("FAIL bp_resp got=%0h/%0h exp=1/5a5a0f0f3c3c9696", lsu_resp_valid, lsu_resp_data); end
    @(negedge clock); #1;
    total++; if (mem_req_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_no_ifu_side got=%0h/%0h exp=0/0", mem_req_valid, lsu_resp_valid); end
  endtask

  task automatic test_spurious();
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL spur_pulse got=%0h/%0h exp=0/0", ifu_resp_valid, lsu_resp_valid); end
    total++; if (lsu_resp_data !== 64'h5A5A_0F0F_3C3C_9696) begin
      bad++; $display("FAIL spur_data got=%0h exp=5a5a0f0f3c3c9696", lsu_resp_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0040; mem_req_ready = 1'b1;
    @(negedge clock);
    ifu_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h7777;
    #1;
    total++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) begin
      bad++; $display("FAIL rmid_discard got=%0h/%0h exp=0/0", mem_req_valid, mem_req_addr); end
    @(negedge clock);
    mem_resp_valid = 1'b0;
    #1;
    total++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_late_resp got=%0h/%0h exp=0/0", ifu_resp_valid, lsu_resp_valid); end
    total++; if (ifu_resp_data !== 64'h0) begin bad++; $display("FAIL rmid_data got=%0h exp=0", ifu_resp_data); end
    ifu_req_valid = 1'b1;
    #1;
    total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%0h exp=1", ifu_req_ready); end
    ifu_req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data;
    @(negedge clock);
    mem_req_ready = 1'b1; ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0100;
    #1;
    total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0h exp=1", ifu_req_ready); end
    for (int r = 0; r < 3; r++) begin
      @(negedge clock); #1;
      total++; if (mem_req_addr !== 64'h8000_0100 + 64'(r) * 64'd8) begin
        bad++; $display("FAIL b2b_addr r=%0d got=%0h exp=%0h", r, mem_req_addr, 64'h8000_0100 + 64'(r) * 64'd8); end
      ifu_req_addr = 64'h8000_0100 + 64'(r + 1) * 64'd8;
      @(negedge clock);
      exp_data = 64'hA5A5_0000_0000_0000 | 64'(r);
      mem_resp_valid = 1'b1; mem_resp_data = exp_data;
      @(negedge clock);
      mem_resp_valid = 1'b0;
      #1;
      total++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== exp_data) begin
        bad++; $display("FAIL b2b_resp r=%0d got=%0h/%0h exp=1/%0h", r, ifu_resp_valid, ifu_resp_data, exp_data); end
      total++; if (ifu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_same_cycle r=%0d got=%0h exp=1", r, ifu_req_ready); end
    end
    ifu_req_valid = 1'b0;
    @(negedge clock); #1;
    total++; if (ifu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%0h/%0h exp=0/0", ifu_resp_valid, mem_req_valid); end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_conflict();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
